// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Exposes the live bit pair and enable for a downstream half-subtractor.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             sub_a,
    output logic             sub_b,
    output logic             sub_en
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d        = sa[0] ^ sb[0] ^ brw;
        bnext    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
        res_next = {d, res[WIDTH-1:1]};
    end

    assign sub_a  = sa[0] & busy;
    assign sub_b  = sb[0] & busy;
    assign sub_en = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    res <= res_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    brw <= bnext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bnext;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // back-to-back accept straight out of the result cycle
                        state <= SHIFT;
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=4 cases
// plus a randomized WIDTH=8 regression against an arithmetic model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, bo4, sa4, sb4, en4;
    logic       busy8, done8, bo8, sa8, sb8, en8;
    logic [3:0] diff4;
    logic [7:0] diff8;

    int passed = 0;
    int total  = 0;

    logic [32:0] q4[$];
    logic [32:0] q8[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4),
        .sub_a(sa4), .sub_b(sb4), .sub_en(en4)
    );

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8),
        .sub_a(sa8), .sub_b(sb8), .sub_en(en8)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: plain unsigned arithmetic.
    function automatic logic [32:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        return {(x < y), ((x - y) & m)};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (done4) begin
            if (q4.size() == 0) check("u4_unexpected_done", 1, 0);
            else begin
                e = q4.pop_front();
                check("u4_diff", 32'(diff4), e[31:0]);
                check("u4_borrow", 32'(bo4), 32'(e[32]));
            end
        end
        if (done8) begin
            if (q8.size() == 0) check("u8_unexpected_done", 1, 0);
            else begin
                e = q8.pop_front();
                check("u8_diff", 32'(diff8), e[31:0]);
                check("u8_borrow", 32'(bo8), 32'(e[32]));
            end
        end
    end

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        start4 = 1'b1; a4 = x; b4 = y;
        q4.push_back(model(4, 32'(x), 32'(y)));
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, nd;
        logic [7:0] x, y;
        rst = 1'b1; start4 = 0; start8 = 0;
        a4 = 0; b4 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy4), 0);
        check("rst_done", 32'(done4), 0);
        check("rst_diff", 32'(diff4), 0);
        check("rst_borrow", 32'(bo4), 0);
        check("rst_sub_en", 32'(en4), 0);
        check("rst_sub_a", 32'(sa4), 0);

        // 5 - 3 with bit-tap sequence
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd3;
        q4.push_back(model(4, 5, 3));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            check("tap_busy", 32'(busy4), 1);
            check("tap_en", 32'(en4), 1);
            check("tap_a", 32'(sa4), 32'((4'd5 >> i) & 4'd1));
            check("tap_b", 32'(sb4), 32'((4'd3 >> i) & 4'd1));
        end
        @(negedge clk);
        check("done_pulse", 32'(done4), 1);
        check("done_busy", 32'(busy4), 0);
        check("done_sub_a", 32'(sa4), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done4), 0);

        op4(4'd3, 4'd5);
        op4(4'd0, 4'd0);
        op4(4'hF, 4'hF);
        op4(4'd0, 4'd1);

        // start held high, operands changed mid-op, new pair in DONE
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd2;
        q4.push_back(model(4, 9, 2));
        @(negedge clk);
        a4 = 4'hC; b4 = 4'h5;
        repeat (3) @(negedge clk);
        a4 = 4'd1; b4 = 4'd2;
        q4.push_back(model(4, 1, 2));
        @(negedge clk);
        check("b2b_first_done", 32'(done4), 1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) start4 = 1'b0;
        end while (!done4 && gap < 20);
        check("b2b_gap", 32'(gap), 5);
        repeat (2) @(negedge clk);

        // start during SHIFT is ignored
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd3;
        q4.push_back(model(4, 7, 3));
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'hA; b4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) nd++;
        end
        check("ignored_start_dones", 32'(nd), 1);

        // reset in the middle of an operation
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy4), 0);
        check("abort_done", 32'(done4), 0);
        check("abort_diff", 32'(diff4), 0);
        check("abort_borrow", 32'(bo4), 0);
        check("abort_sub_en", 32'(en4), 0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) nd++;
        end
        check("abort_no_done", 32'(nd), 0);
        op4(4'd6, 4'd6);

        // WIDTH=8 random regression
        for (int n = 0; n < 200; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (n == 0) begin x = 8'h00; y = 8'hFF; end
            if (n == 1) begin x = 8'hFF; y = 8'h00; end
            start8 = 1'b1; a8 = x; b8 = y;
            q8.push_back(model(8, 32'(x), 32'(y)));
            @(negedge clk);
            start8 = 1'b0;
            repeat (8 + $urandom_range(0, 3)) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        check("q4_drained", 32'(q4.size()), 0);
        check("q8_drained", 32'(q8.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
